alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 32 +++
 rtl/alu_sequencer_if.sv | 33 +++
 rtl/alu_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: ALU opcodes, flag positions,
// sequencer states and the iteration count.
package alu_sequencer_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned OPC_W      = 4;
  localparam int unsigned FLAG_W     = 3;
  localparam int unsigned ITERATIONS = 16;
  localparam int unsigned CNT_W      = $clog2(ITERATIONS);

  localparam logic [OPC_W-1:0] A_ADD = 4'h0;
  localparam logic [OPC_W-1:0] A_SUB = 4'h1;
  localparam logic [OPC_W-1:0] A_AND = 4'h2;
  localparam logic [OPC_W-1:0] A_OR  = 4'h3;
  localparam logic [OPC_W-1:0] A_XOR = 4'h4;

  localparam int unsigned FLAG_CF = 0;
  localparam int unsigned FLAG_ZF = 1;
  localparam int unsigned FLAG_NF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } seq_op_e;

endpackage

// File: rtl/alu_sequencer_if.sv
// Bundle of the sequencer's request, result, EX-stage and shared-ALU signals.
interface alu_sequencer_if
  import alu_sequencer_pkg::*;
;
  logic              start;
  logic              op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [OPC_W-1:0]  ex_opcode;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [OPC_W-1:0]  alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic [FLAG_W-1:0] alu_flags;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] res_hi;
  logic [DATA_W-1:0] res_lo;
  logic              div0;

  modport slave (
    input  start, op, src_a, src_b, ex_opcode, ex_a, ex_b, alu_result, alu_flags,
    output alu_opcode, alu_a, alu_b, busy, done, res_hi, res_lo, div0
  );

  modport master (
    output start, op, src_a, src_b, ex_opcode, ex_a, ex_b, alu_result, alu_flags,
    input  alu_opcode, alu_a, alu_b, busy, done, res_hi, res_lo, div0
  );

endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle shift-add multiply / restoring divide that borrows the shared
// ALU for 16 cycles and otherwise passes the EX-stage request straight through.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  alu_sequencer_if.slave  sif
);

  seq_state_e        state_q, state_d;
  seq_op_e           op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_hi_q, res_hi_d;
  logic [DATA_W-1:0] res_lo_q, res_lo_d;
  logic              div0_q, div0_d;
  logic [DATA_W-1:0] t;
  logic              take;
  logic              unused_flags;

  // acc holds the product high half / remainder; lo holds the multiplier
  // (shifted out as product low) / dividend (shifted into quotient).
  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    lo_d           = lo_q;
    b_d            = b_q;
    res_hi_d       = res_hi_q;
    res_lo_d       = res_lo_q;
    div0_d         = div0_q;
    t              = {acc_q[DATA_W-2:0], lo_q[DATA_W-1]};
    take           = 1'b0;
    unused_flags   = ^sif.alu_flags[FLAG_NF:FLAG_ZF];
    sif.alu_opcode = sif.ex_opcode;
    sif.alu_a      = sif.ex_a;
    sif.alu_b      = sif.ex_b;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (sif.start) begin
          op_d  = seq_op_e'(sif.op);
          cnt_d = '0;
          acc_d = '0;
          lo_d  = sif.op ? sif.src_a : sif.src_b;
          b_d   = sif.op ? sif.src_b : sif.src_a;
          if (sif.op && (sif.src_b == '0)) begin
            state_d  = DONE;
            res_hi_d = sif.src_a;
            res_lo_d = '1;
            div0_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          sif.alu_opcode = A_ADD;
          sif.alu_a      = acc_q;
          sif.alu_b      = lo_q[0] ? b_q : '0;
          {acc_d, lo_d}  = {sif.alu_flags[FLAG_CF], sif.alu_result, lo_q[DATA_W-1:1]};
        end else begin
          sif.alu_opcode = A_SUB;
          sif.alu_a      = t;
          sif.alu_b      = b_q;
          // A carry-out of the shifted remainder means t exceeds 16 bits, so it always fits.
          take  = acc_q[DATA_W-1] | ~sif.alu_flags[FLAG_CF];
          acc_d = take ? sif.alu_result : t;
          lo_d  = {lo_q[DATA_W-2:0], take};
        end
        if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
          state_d  = DONE;
          res_hi_d = acc_d;
          res_lo_d = lo_d;
          if (op_q == OP_DIV) begin
            div0_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      b_q      <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      b_q      <= b_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      div0_q   <= div0_d;
    end
  end

  always_comb begin
    sif.busy   = (state_q == RUN);
    sif.done   = (state_q == DONE);
    sif.res_hi = res_hi_q;
    sif.res_lo = res_lo_q;
    sif.div0   = div0_q;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench: shared ALU, arithmetic reference model, per-cycle
// compare process, directed literal cases and randomized operations.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (bus.slave)
  );

  logic [16:0] alu_wide;
  always_comb begin
    alu_wide = '0;
    case (bus.alu_opcode)
      A_ADD:   alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      A_SUB:   alu_wide = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      A_AND:   alu_wide = {1'b0, bus.alu_a & bus.alu_b};
      A_OR:    alu_wide = {1'b0, bus.alu_a | bus.alu_b};
      A_XOR:   alu_wide = {1'b0, bus.alu_a ^ bus.alu_b};
      default: alu_wide = '0;
    endcase
    bus.alu_result = alu_wide[15:0];
    bus.alu_flags  = {alu_wide[15], alu_wide[15:0] == 16'h0, alu_wide[16]};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a countdown to completion and the arithmetic answer.
  int          m_left = 0;
  bit          m_done = 1'b0;
  logic [15:0] m_hi   = '0;
  logic [15:0] m_lo   = '0;
  bit          m_div0 = 1'b0;
  logic [15:0] p_hi   = '0;
  logic [15:0] p_lo   = '0;
  bit          p_isdiv = 1'b0;
  logic [31:0] prod;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_div0 = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_hi   = p_hi;
        m_lo   = p_lo;
        if (p_isdiv) m_div0 = 1'b0;
      end
    end else if (bus.start) begin
      m_done = 1'b0;
      if (bus.op) begin
        if (bus.src_b == 16'h0) begin
          m_done = 1'b1; m_hi = bus.src_a; m_lo = 16'hFFFF; m_div0 = 1'b1;
        end else begin
          p_hi = bus.src_a % bus.src_b; p_lo = bus.src_a / bus.src_b;
          p_isdiv = 1'b1; m_left = 16;
        end
      end else begin
        prod = 32'(bus.src_a) * 32'(bus.src_b);
        p_hi = prod[31:16]; p_lo = prod[15:0]; p_isdiv = 1'b0; m_left = 16;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 48'(bus.busy), 48'(m_left > 0));
      check("done", 48'(bus.done), 48'(m_done));
      check("res_hi", 48'(bus.res_hi), 48'(m_hi));
      check("res_lo", 48'(bus.res_lo), 48'(m_lo));
      check("div0", 48'(bus.div0), 48'(m_div0));
      if (m_left == 0)
        check("passthru", 48'({bus.alu_opcode, bus.alu_a, bus.alu_b}),
              48'({bus.ex_opcode, bus.ex_a, bus.ex_b}));
    end
  end

  task automatic rand_ex();
    bus.ex_opcode = 4'($urandom_range(0, 7));
    bus.ex_a      = 16'($urandom);
    bus.ex_b      = 16'($urandom);
  endtask

  task automatic do_op(input bit op_i, input logic [15:0] a, input logic [15:0] b,
                       input bit b2b, input int mid, input logic [15:0] exp_hi,
                       input logic [15:0] exp_lo, input int exp_lat, input string name);
    int cyc;
    bit seen_busy;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    bus.start = 1'b1; bus.op = op_i; bus.src_a = a; bus.src_b = b;
    cyc = 0; seen_busy = 1'b0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      rand_ex();
      bus.start = (cyc == mid);
      bus.op    = ~op_i;
      bus.src_a = ~a;
      bus.src_b = b ^ 16'h00F1;
      if (bus.busy) seen_busy = 1'b1;
      if (bus.done || cyc >= 40) break;
    end
    check({name, " latency"}, 48'(cyc), 48'(exp_lat));
    check({name, " res_hi"}, 48'(bus.res_hi), 48'(exp_hi));
    check({name, " res_lo"}, 48'(bus.res_lo), 48'(exp_lo));
    check({name, " busy_seen"}, 48'(seen_busy), 48'(exp_lat != 1));
  endtask

  initial begin
    bit          op_r;
    logic [15:0] a_r, b_r, hi_r, lo_r;
    logic [31:0] pr;
    int          lat_r, mid_r;

    bus.start = 1'b0; bus.op = 1'b0; bus.src_a = '0; bus.src_b = '0;
    bus.ex_opcode = A_ADD; bus.ex_a = 16'h1111; bus.ex_b = 16'h2222;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("reset busy", 48'(bus.busy), 48'(0));
    check("reset done", 48'(bus.done), 48'(0));
    check("reset res", 48'({bus.res_hi, bus.res_lo}), 48'(0));
    check("reset div0", 48'(bus.div0), 48'(0));
    check("reset alu_result", 48'(bus.alu_result), 48'(16'h3333));

    do_op(1'b0, 16'd3, 16'd5, 1'b0, 0, 16'h0000, 16'h000F, 17, "mul3x5");
    do_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 0, 16'hFFFE, 16'h0001, 17, "mulmax");
    do_op(1'b1, 16'd100, 16'd7, 1'b0, 0, 16'd2, 16'd14, 17, "div100_7");
    do_op(1'b1, 16'hFFFF, 16'd1, 1'b1, 0, 16'h0000, 16'hFFFF, 17, "divffff_1_b2b");
    check("div0 clear", 48'(bus.div0), 48'(0));
    do_op(1'b1, 16'h1234, 16'h0000, 1'b0, 0, 16'h1234, 16'hFFFF, 1, "div_by_0");
    check("div0 set", 48'(bus.div0), 48'(1));
    do_op(1'b0, 16'h1234, 16'h0100, 1'b0, 5, 16'h0012, 16'h3400, 17, "mul_midstart");
    do_op(1'b0, 16'h8000, 16'h0003, 1'b1, 0, 16'h0001, 16'h8000, 17, "mul_b2b");

    // Reset in the middle of a multiply.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 1'b0; bus.src_a = 16'h00FF; bus.src_b = 16'h0101;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    check("iter8 busy", 48'(bus.busy), 48'(1));
    rst_n = 1'b0;
    bus.ex_opcode = A_AND; bus.ex_a = 16'hF0F0; bus.ex_b = 16'h3C3C;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst busy", 48'(bus.busy), 48'(0));
    check("midrst done", 48'(bus.done), 48'(0));
    check("midrst res", 48'({bus.res_hi, bus.res_lo}), 48'(0));
    check("midrst div0", 48'(bus.div0), 48'(0));
    check("midrst opcode", 48'(bus.alu_opcode), 48'(A_AND));
    check("midrst and", 48'(bus.alu_result), 48'(16'h3030));
    repeat (20) @(posedge clk);
    #1;

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        rand_ex();
      end
      op_r = 1'($urandom);
      a_r  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      case ($urandom_range(0, 5))
        0:       b_r = 16'h0000;
        1:       b_r = 16'($urandom_range(1, 9));
        default: b_r = 16'($urandom);
      endcase
      mid_r = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 15)) : 0;
      if (op_r && b_r == 16'h0) begin
        hi_r = a_r; lo_r = 16'hFFFF; lat_r = 1;
      end else if (op_r) begin
        hi_r = a_r % b_r; lo_r = a_r / b_r; lat_r = 17;
      end else begin
        pr = 32'(a_r) * 32'(b_r);
        hi_r = pr[31:16]; lo_r = pr[15:0]; lat_r = 17;
      end
      do_op(op_r, a_r, b_r, 1'($urandom), mid_r, hi_r, lo_r, lat_r, "rand");
    end

    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
